// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I core: word RAM plus an MMIO window
// holding RGB PWM/LED control, millis/micros counters and a sticky misaligned-store flag.
module mem_responder #(
  parameter int    MEM_WORDS = 2048,
  parameter string INIT_FILE = "",
  parameter int    CLK_HZ    = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
  localparam int MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int US_DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
  localparam logic [31:0] MS_TC = 32'(MS_DIV - 1);
  localparam logic [31:0] US_TC = 32'(US_DIV - 1);

  localparam logic [31:0] ADDR_LEDCTL = 32'hFFFF_FFFC;
  localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFF0;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] word_adr;
  logic [AW-1:0] ram_idx;
  logic        is_ram;
  logic        hit_ledctl;
  logic        hit_status;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic        bad_store;
  logic        store_ok;
  logic [31:0] rd_next;

  logic [24:0] ledctl;
  logic [7:0]  pwm_cnt;
  logic [31:0] ms_pre;
  logic [31:0] us_pre;
  logic [31:0] millis;
  logic [31:0] micros;
  logic        misaligned;

  assign word_adr   = {Adr[31:2], 2'b00};
  assign ram_idx    = Adr[AW+1:2];
  assign is_ram     = (Adr < RAM_BYTES);
  assign hit_ledctl = (word_adr == ADDR_LEDCTL);
  assign hit_status = (word_adr == ADDR_STATUS);
  assign store_ok   = MemWrite && !bad_store;

  // Store sizing: byte enables and lane-replicated data, shared by RAM and LEDCTL.
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = WriteData;
    bad_store   = 1'b0;
    case (funct3)
      3'b000: begin
        be          = 4'b0001 << Adr[1:0];
        wdata_lanes = {4{WriteData[7:0]}};
      end
      3'b001: begin
        if (Adr[0]) begin
          bad_store = 1'b1;
        end else begin
          be          = Adr[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{WriteData[15:0]}};
        end
      end
      3'b010: begin
        if (Adr[1:0] != 2'b00) bad_store = 1'b1;
        else                   be        = 4'b1111;
      end
      default: bad_store = 1'b1;
    endcase
  end

  always_comb begin
    rd_next = 32'h0;
    if (is_ram) begin
      rd_next = mem[ram_idx];
    end else begin
      case (word_adr)
        ADDR_LEDCTL: rd_next = {7'h0, ledctl};
        ADDR_MILLIS: rd_next = millis;
        ADDR_MICROS: rd_next = micros;
        ADDR_STATUS: rd_next = {31'h0, misaligned};
        default:     rd_next = 32'h0;
      endcase
    end
  end

  // RAM has no reset of its own, but stores seen while in reset are dropped.
  always_ff @(posedge clk) begin
    if (reset && store_ok && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData   <= 32'h0;
      ledctl     <= 25'h0;
      pwm_cnt    <= 8'h0;
      ms_pre     <= 32'h0;
      us_pre     <= 32'h0;
      millis     <= 32'h0;
      micros     <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      ReadData <= rd_next;
      pwm_cnt  <= pwm_cnt + 8'd1;

      if (store_ok && hit_ledctl) begin
        for (int i = 0; i < 3; i++) begin
          if (be[i]) ledctl[8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
        if (be[3]) ledctl[24] <= wdata_lanes[24];
      end

      // A bad store anywhere sets the flag, even one aimed at STATUS itself.
      if (MemWrite && bad_store)    misaligned <= 1'b1;
      else if (store_ok && hit_status) misaligned <= 1'b0;

      if (ms_pre == MS_TC) begin
        ms_pre <= 32'h0;
        millis <= millis + 32'd1;
      end else begin
        ms_pre <= ms_pre + 32'd1;
      end

      if (us_pre == US_TC) begin
        us_pre <= 32'h0;
        micros <= micros + 32'd1;
      end else begin
        us_pre <= us_pre + 32'd1;
      end
    end
  end

  assign led   = ledctl[24];
  assign red   = (pwm_cnt < ledctl[7:0]);
  assign green = (pwm_cnt < ledctl[15:8]);
  assign blue  = (pwm_cnt < ledctl[23:16]);

endmodule
